// File: rtl/pulsed_output_multiplexer_pkg.sv
// Default geometry of the shutter output multiplexer.
package pulsed_output_multiplexer_pkg;
    localparam int OMUX_DEF_WIDTH = 64;
    localparam int OMUX_DEF_DEPTH = 4;
    localparam int OMUX_DEF_PTR_W = 2;
endpackage

// File: rtl/output_mux_defs.vh
// Pulse-end entry layout shared by the multiplexer and its queue: {mask, value}.
`ifndef OUTPUT_MUX_DEFS_VH
`define OUTPUT_MUX_DEFS_VH
`define OMUX_ENTRY_W(w) (2*(w))
`define OMUX_MASK(e, w) e[2*(w)-1:(w)]
`define OMUX_VAL(e, w) e[(w)-1:0]
`endif

// File: rtl/pulsed_output_multiplexer_pulse_end_fifo.sv
// Pulse-end queue: first-word fall-through FIFO, state changes 1 cycle after push/pop.
// A push into a full queue is dropped unless a pop happens in the same cycle.
module pulse_end_fifo
    import pulsed_output_multiplexer_pkg::*;
#(
    parameter int DATA_W = 2 * OMUX_DEF_WIDTH,
    parameter int DEPTH  = OMUX_DEF_DEPTH,
    parameter int PTR_W  = OMUX_DEF_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok, pop_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/pulsed_output_multiplexer.sv
// Shutter line driver: masked updates plus queued pulse-end restores popped on wait-timer rising edges.
// Output latency 1 cycle; no backpressure, a pulse push into a full queue is dropped and flagged sticky.
`include "output_mux_defs.vh"
module pulsed_output_multiplexer
    import pulsed_output_multiplexer_pkg::*;
#(
    parameter int WIDTH = OMUX_DEF_WIDTH,
    parameter int DEPTH = OMUX_DEF_DEPTH,
    parameter int PTR_W = OMUX_DEF_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update,
    input  logic             pulse_mode,
    input  logic [WIDTH-1:0] update_mask,
    input  logic [WIDTH-1:0] shutter_in,
    input  logic [WIDTH-1:0] pulse_end_shutter,
    input  logic             wait_expired,
    input  logic             clear_errors,
    output logic [WIDTH-1:0] shutter_out,
    output logic [PTR_W:0]   pending_count,
    output logic             fifo_full,
    output logic             overflow
);
    localparam int ENTRY_W = `OMUX_ENTRY_W(WIDTH);

    logic               wait_q, wait_d;
    logic [WIDTH-1:0]   shutter_q, shutter_d;
    logic               overflow_q, overflow_d;
    logic               exp_edge, push, pop, fifo_empty;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    assign exp_edge   = wait_expired & ~wait_q;
    assign pop        = exp_edge & ~fifo_empty;
    assign push       = update & pulse_mode;
    assign push_entry = {update_mask, pulse_end_shutter};

    pulse_end_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .count (pending_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop is merged before the update so a same-cycle update wins on overlapping bits.
    always_comb begin
        wait_d    = wait_expired;
        shutter_d = shutter_q;
        if (pop) begin
            shutter_d = (shutter_d & ~`OMUX_MASK(head_entry, WIDTH))
                      | (`OMUX_VAL(head_entry, WIDTH) & `OMUX_MASK(head_entry, WIDTH));
        end
        if (update) begin
            shutter_d = (shutter_d & ~update_mask) | (shutter_in & update_mask);
        end
        overflow_d = (overflow_q & ~clear_errors) | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q     <= 1'b0;
            shutter_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            shutter_q  <= shutter_d;
            overflow_q <= overflow_d;
        end
    end

    assign shutter_out = shutter_q;
    assign overflow    = overflow_q;
endmodule
